addsub_serial: RTL and testbench

Parametrised, multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock through a single narrow chunk adder with a registered carry. It trades latency for area and replaces fixed 8-bit combinational adders where wide operands (e.g. 32-bit) feed a sequential datapath. Operand capture uses a start/ready handshake, and completion is signalled by a one-cycle valid pulse. The block also produces carry, signed-overflow and zero flags.

---
 rtl/adder_pkg.sv | 17 +
 rtl/addsub_chunk.sv | 19 +
 rtl/addsub_serial.sv | 115 +++++++++++
 tb/tb_addsub_serial.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunk steps per operation; 0 flags an illegal WIDTH/CHUNK pair.
    function automatic int chunk_count(int width, int chunk);
        if (chunk < 1 || width < chunk || (width % chunk) != 0)
            return 0;
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice returning sum, carry out and carry into its MSB.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(cin);
        // The MSB sum bit is a^b^carry_in, so the incoming carry falls out by XOR.
        c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor that walks the operands CHUNK bits per clock
// through one narrow adder slice with a registered carry.
module addsub_serial
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = chunk_count(WIDTH, CHUNK);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (N == 0) begin : g_illegal_params
        $error("addsub_serial: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_upd;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             accept, last_step;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_out, c_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                valid      = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = ready & start;
    assign last_step = (state == RUN) && (cnt == LAST);
    assign a_chunk   = a_reg[int'(cnt)*CHUNK +: CHUNK];
    assign b_chunk   = b_reg[int'(cnt)*CHUNK +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .sum   (s_chunk),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // Full result with the current slice merged in, so zero sees the final value on the last step.
    always_comb begin
        sum_upd = sum;
        sum_upd[int'(cnt)*CHUNK +: CHUNK] = s_chunk;
    end

    // NOTE: operand registers are reset too, keeping every flop in a known state after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum   <= sum_upd;
            carry <= c_out;
            cnt   <= cnt + CNT_W'(1);
            if (last_step) begin
                cout <= c_out;
                ovf  <= c_msb ^ c_out;
                zero <= ~|sum_upd;
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed vectors, handshake/reset sequences
// and a random sweep over several WIDTH/CHUNK configurations.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub, cin;
    logic [31:0] a, b;
    logic        ready, valid;
    logic [31:0] sum;
    logic        cout, ovf, zero;
    logic        sweep_go = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .valid (valid),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one operation from a negedge with ready=1; return negedges until valid is seen.
    task automatic run_op(input logic s, input logic c, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat);
        @(negedge clk);
        sub = s; cin = c; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; sub = ~s; cin = ~c;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < 20);
    endtask

    typedef struct {
        logic        sub;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          lat;
        logic [11:0] vmask;

        vecs[0] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000FFFF, 32'h00000000, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000007, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        check("reset ready", 32'(ready), 32'd1);
        check("reset valid", 32'(valid), 32'd0);
        check("reset sum",   sum,        32'd0);
        check("reset flags", 32'({cout, ovf, zero}), 32'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd5);
            check($sformatf("v%0d sum", i),  sum,         vecs[i].sum);
            check($sformatf("v%0d cout", i), 32'(cout),   32'(vecs[i].cout));
            check($sformatf("v%0d ovf", i),  32'(ovf),    32'(vecs[i].ovf));
            check($sformatf("v%0d zero", i), 32'(zero),   32'(vecs[i].zero));
            @(negedge clk);
            check($sformatf("v%0d valid one cycle", i), 32'({valid, ready}), 32'b01);
        end

        // start pulsed throughout RUN must be ignored
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 32'h00001234; b = 32'h00004321; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n < 5) begin
                check($sformatf("run busy n%0d", n), 32'({ready, valid}), 32'b00);
                a = $urandom;
            end else begin
                start = 1'b0;
                check("run ignore valid", 32'(valid), 32'd1);
                check("run ignore sum",   sum, 32'h00005555);
                check("run ignore flags", 32'({cout, ovf, zero}), 32'b000);
            end
        end
        @(negedge clk);
        check("run ignore idle", 32'({valid, ready}), 32'b01);

        // start held across DONE: back-to-back accept
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 32'h0F0F0F0F; b = 32'h01010101; start = 1'b1;
        @(posedge clk);
        #1;
        sub = 1'b1; a = 32'h80000000; b = 32'h00000001;
        vmask = '0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            vmask[n] = valid;
            if (n == 5) check("b2b first sum", sum, 32'h10101010);
            if (n == 6) start = 1'b0;
            if (n == 10) begin
                check("b2b second sum",   sum, 32'h7FFFFFFF);
                check("b2b second flags", 32'({cout, ovf, zero}), 32'b110);
            end
        end
        check("b2b valid pattern", 32'(vmask), 32'h00000420);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        sub = 1'b0; cin = 1'b0; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun reset sum",   sum, 32'd0);
        check("midrun reset flags", 32'({cout, ovf, zero}), 32'b001);
        check("midrun reset hs",    32'({ready, valid}), 32'b10);
        @(negedge clk);
        rst_n = 1'b1;
        vmask = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            vmask[n] = valid;
        end
        check("midrun no valid", 32'(vmask), 32'd0);
        run_op(1'b0, 1'b0, 32'h11111111, 32'h22222222, lat);
        check("post reset latency", 32'(lat), 32'd5);
        check("post reset sum",     sum, 32'h33333333);

        // random sweep over the other configurations
        sweep_go = 1'b1;
        for (int t = 0; t < 60000; t++) begin
            if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
            @(negedge clk);
        end
        check("sweep finished", 32'({g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}), 32'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    localparam int SW_W [3] = '{8, 16, 32};
    localparam int SW_C [3] = '{8, 4, 1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W  = SW_W[gi];
        localparam int C  = SW_C[gi];
        localparam int NS = W / C;

        logic         s_start, s_sub, s_cin, s_ready, s_valid, s_cout, s_ovf, s_zero;
        logic [W-1:0] s_a, s_b, s_sum;
        logic         done = 1'b0;

        addsub_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (s_start),
            .sub   (s_sub),
            .cin   (s_cin),
            .a     (s_a),
            .b     (s_b),
            .ready (s_ready),
            .valid (s_valid),
            .sum   (s_sum),
            .cout  (s_cout),
            .ovf   (s_ovf),
            .zero  (s_zero)
        );

        initial begin
            logic [W:0]   full;
            logic [W-1:0] bb, exp_sum;
            logic         exp_ovf;
            int           lat;
            string        tag;

            s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
            tag = $sformatf("w%0dc%0d", W, C);
            wait (sweep_go);
            @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                s_a   = W'($urandom);
                s_b   = (n % 16 == 0) ? s_a : W'($urandom);
                s_sub = 1'($urandom_range(0, 1));
                s_cin = 1'($urandom_range(0, 1));
                bb      = s_sub ? ~s_b : s_b;
                full    = {1'b0, s_a} + {1'b0, bb} + (W + 1)'(s_sub ? 1'b1 : s_cin);
                exp_sum = full[W-1:0];
                exp_ovf = (s_a[W-1] == bb[W-1]) && (exp_sum[W-1] != s_a[W-1]);
                check({tag, " ready"}, 32'(s_ready), 32'd1);
                s_start = 1'b1;
                @(posedge clk);
                #1;
                s_start = 1'b0; s_a = ~s_a; s_b = W'($urandom); s_sub = ~s_sub;
                lat = 0;
                do begin
                    @(negedge clk);
                    lat++;
                end while (!s_valid && lat < NS + 4);
                check({tag, " latency"}, 32'(lat),    32'(NS + 1));
                check({tag, " sum"},     32'(s_sum),  32'(exp_sum));
                check({tag, " cout"},    32'(s_cout), 32'(full[W]));
                check({tag, " ovf"},     32'(s_ovf),  32'(exp_ovf));
                check({tag, " zero"},    32'(s_zero), 32'(exp_sum == '0));
            end
            done = 1'b1;
        end
    end

endmodule
